reg64_unpack: RTL and testbench
===============================

REG64_UNPACK -- requirements
Module: reg64_unpack

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = beat 0 carries bits [15:0]; 0 = beat 0 carries bits [63:48].
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ld_valid, input, 1, 64-bit load word present.
REQ-005 The block SHALL have port ld_ready, output, 1, block accepts a load this cycle.
REQ-006 The block SHALL have port ld_data, input, 64, word to unpack.
REQ-007 The block SHALL have port flush, input, 1, synchronous abort of the word in progress.
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds a valid beat.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the beat.
REQ-010 The block SHALL have port out_data, output, 16, current 16-bit beat.
REQ-011 The block SHALL have port out_idx, output, 2, beat number 0..3 within the word.
REQ-012 The block SHALL have port out_last, output, 1, high exactly when out_valid and out_idx==3.

Function
REQ-013 The block SHALL implement two states: IDLE (no word held) and SEND (word held, beats pending).
REQ-014 The block SHALL drive ld_ready=1 in IDLE, and in SEND only when out_idx==3 and out_ready=1; it SHALL force ld_ready=0 while flush=1.
REQ-015 A load SHALL occur when ld_valid and ld_ready are both 1: ld_data is captured into a 64-bit holding register, beat counter cleared to 0, and state becomes SEND.
REQ-016 out_valid SHALL be 1 exactly in SEND, so the first beat appears the cycle after the load (latency 1).
REQ-017 out_data SHALL be holding-register slice [16*k+15:16*k] with k=out_idx when LSB_FIRST=1, or k=3-out_idx when LSB_FIRST=0.
REQ-018 A beat transfer SHALL occur when out_valid and out_ready are both 1; the counter then increments by 1.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-020 On transfer of beat 3 without a simultaneous load, the state SHALL return to IDLE with out_valid=0 next cycle.
REQ-021 On transfer of beat 3 with a simultaneous load (back-to-back), the state SHALL remain SEND with the new word and out_idx=0 next cycle, giving zero bubble cycles.
REQ-022 flush=1 SHALL have highest priority: next cycle state=IDLE, out_valid=0, counter=0; any beat transfer or load in that cycle SHALL be discarded.
REQ-023 ld_data changes while in SEND SHALL NOT affect out_data.

Reset
REQ-024 While rst=0, the block SHALL asynchronously force state=IDLE, counter=0, holding register=0, out_valid=0, out_last=0, out_data=0, out_idx=0, and drive ld_ready=0.
REQ-025 Reset asserted mid-word SHALL discard all remaining beats; after rst returns to 1, ld_ready SHALL be 1 at the first clock edge.

Configuration
REQ-026 With macro REG64_UNPACK_PARITY_EN defined, the block SHALL add output out_par (1 bit) equal to even parity (XOR) of out_data, valid whenever out_valid=1, and 0 in reset.
REQ-027 Without REG64_UNPACK_PARITY_EN, port out_par SHALL NOT exist and no parity logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover single word: load 0x4444_3333_2222_1111, out_ready=1 held -> beats 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles starting 1 cycle after load, out_last only on 0x4444, then IDLE.
REQ-029 The bench SHALL cover backpressure: out_ready=0 for 3 cycles during beat 1 of 0x4444_3333_2222_1111 -> out_data stays 0x2222 with out_idx=1, and ld_ready=0 throughout.
REQ-030 The bench SHALL cover back-to-back: second word 0xDDDD_CCCC_BBBB_AAAA offered with ld_valid during beat 3 -> 0x4444 followed immediately by 0xAAAA, 8 beats in 8 cycles.
REQ-031 The bench SHALL cover flush: flush=1 at beat 2 -> out_valid=0 next cycle, no 0x3333/0x4444 emitted, and a load in the flush cycle is ignored.
REQ-032 The bench SHALL cover async reset: rst=0 mid-word between clock edges -> outputs zero immediately, not at the next edge; with LSB_FIRST=0 a rerun of REQ-028 yields 0x4444 first.
REQ-033 The bench SHALL cover parity: with REG64_UNPACK_PARITY_EN defined, beat 0x0001 -> out_par=1 and beat 0x0003 -> out_par=0.

Source files
------------

// File: rtl/reg64_unpack.sv
// Unpacks a 64-bit load word into four 16-bit beats using valid/ready handshakes on both sides.
// Optional out_par (XOR of out_data) is present only when REG64_UNPACK_PARITY_EN is defined.
module reg64_unpack #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [63:0] ld_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [1:0]  out_idx,
`ifdef REG64_UNPACK_PARITY_EN
   output logic        out_par,
`endif
   output logic        out_last
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [63:0] hold_q;
   logic        hold_load;
   logic        ld_fire;
   logic        beat_fire;
   logic [1:0]  slice_sel;

   assign out_valid = (state_q == SEND);
   assign out_idx   = cnt_q;
   assign out_last  = out_valid && (cnt_q == 2'd3);

   // ld_ready is held low during reset and flush; a new word may be taken as beat 3 leaves.
   assign ld_ready  = rst && !flush &&
                      ((state_q == IDLE) || (out_last && out_ready));

   assign ld_fire   = ld_valid && ld_ready;
   assign beat_fire = out_valid && out_ready;

   assign slice_sel = LSB_FIRST ? cnt_q : (2'd3 - cnt_q);
   assign out_data  = hold_q[16*slice_sel +: 16];

`ifdef REG64_UNPACK_PARITY_EN
   assign out_par = ^out_data;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      hold_load = 1'b0;

      if (flush) begin
         state_d = IDLE;
         cnt_d   = 2'd0;
      end else if (ld_fire) begin
         state_d   = SEND;
         cnt_d     = 2'd0;
         hold_load = 1'b1;
      end else if (beat_fire) begin
         if (cnt_q == 2'd3) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the holding register is reset so out_data (and parity) read zero during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= 64'd0;
      end else if (hold_load) begin
         hold_q <= ld_data;
      end
   end

endmodule

// File: tb/tb_reg64_unpack.sv
// Directed, table-driven bench for reg64_unpack; one LSB-first and one MSB-first instance share stimulus.
module tb_reg64_unpack;

   localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
   localparam logic [63:0] W2 = 64'hDDDD_CCCC_BBBB_AAAA;

   logic        clk;
   logic        rst;
   logic        ld_valid;
   logic [63:0] ld_data;
   logic        flush;
   logic        out_ready;

   logic        ld_ready, out_valid, out_last;
   logic [15:0] out_data;
   logic [1:0]  out_idx;
   logic        m_ld_ready, m_valid, m_last;
   logic [15:0] m_data;
   logic [1:0]  m_idx;
`ifdef REG64_UNPACK_PARITY_EN
   logic        out_par, m_par;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ldv;
      logic [63:0] ldd;
      logic        ordy;
      logic        fl;
      logic        ev;
      logic [15:0] ed;
      logic [15:0] em;
      logic [1:0]  ei;
      logic        el;
      logic        elr;
   } vec_t;

   vec_t vecs[$];

   reg64_unpack #(.LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx),
`ifdef REG64_UNPACK_PARITY_EN
      .out_par(out_par),
`endif
      .out_last(out_last)
   );

   reg64_unpack #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(m_ld_ready), .ld_data(ld_data),
      .flush(flush), .out_valid(m_valid), .out_ready(out_ready), .out_data(m_data),
      .out_idx(m_idx),
`ifdef REG64_UNPACK_PARITY_EN
      .out_par(m_par),
`endif
      .out_last(m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic ldv, input logic [63:0] ldd, input logic ordy, input logic fl,
                      input logic ev, input logic [15:0] ed, input logic [15:0] em,
                      input logic [1:0] ei, input logic el, input logic elr);
      vec_t v;
      v.ldv = ldv; v.ldd = ldd; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.ed = ed; v.em = em; v.ei = ei; v.el = el; v.elr = elr;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs at the falling edge and compare outputs before the next rising edge.
   task automatic step(input vec_t v);
      @(negedge clk);
      ld_valid  = v.ldv;
      ld_data   = v.ldd;
      out_ready = v.ordy;
      flush     = v.fl;
      #1;
      check("out_valid", out_valid, v.ev);
      check("ld_ready", ld_ready, v.elr);
      check("out_idx", out_idx, v.ei);
      check("out_last", out_last, v.el);
      check("msb_out_valid", m_valid, v.ev);
      if (v.ev) begin
         check("out_data", out_data, v.ed);
         check("msb_out_data", m_data, v.em);
      end
   endtask

   initial begin
      vec_t pv;
      rst = 1'b0; ld_valid = 1'b0; ld_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_ld_ready", ld_ready, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_last", out_last, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single word, out_ready held high.
      add(1, W1, 1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      add(0, 0,  1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0);
      add(0, 0,  1, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'h3333, 16'h2222, 2, 0, 0);
      add(0, 0,  1, 0, 1, 16'h4444, 16'h1111, 3, 1, 1);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      // Backpressure on beat 1 with a competing load offered; stall on beat 3 then back-to-back.
      add(1, W1, 1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      add(0, 0,  1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0);
      add(1, W2, 0, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(1, W2, 0, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(1, W2, 0, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'h3333, 16'h2222, 2, 0, 0);
      add(1, W2, 0, 0, 1, 16'h4444, 16'h1111, 3, 1, 0);
      add(1, W2, 1, 0, 1, 16'h4444, 16'h1111, 3, 1, 1);
      add(0, 0,  1, 0, 1, 16'hAAAA, 16'hDDDD, 0, 0, 0);
      add(0, 0,  1, 0, 1, 16'hBBBB, 16'hCCCC, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'hCCCC, 16'hBBBB, 2, 0, 0);
      add(0, 0,  1, 0, 1, 16'hDDDD, 16'hAAAA, 3, 1, 1);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      // Clean back-to-back: 8 beats in 8 cycles.
      add(1, W1, 1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      add(0, 0,  1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0);
      add(0, 0,  1, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'h3333, 16'h2222, 2, 0, 0);
      add(1, W2, 1, 0, 1, 16'h4444, 16'h1111, 3, 1, 1);
      add(0, 0,  1, 0, 1, 16'hAAAA, 16'hDDDD, 0, 0, 0);
      add(0, 0,  1, 0, 1, 16'hBBBB, 16'hCCCC, 1, 0, 0);
      add(0, 0,  1, 0, 1, 16'hCCCC, 16'hBBBB, 2, 0, 0);
      add(0, 0,  1, 0, 1, 16'hDDDD, 16'hAAAA, 3, 1, 1);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      // Flush at beat 2 with a load offered in the flush cycle.
      add(1, W1, 1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      add(0, 0,  1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0);
      add(0, 0,  1, 0, 1, 16'h2222, 16'h3333, 1, 0, 0);
      add(1, W2, 1, 1, 1, 16'h3333, 16'h2222, 2, 0, 0);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);
      // Flush while idle blocks a load.
      add(1, W2, 1, 1, 0, 16'h0,    16'h0,    0, 0, 0);
      add(0, 0,  1, 0, 0, 16'h0,    16'h0,    0, 0, 1);

      foreach (vecs[i]) step(vecs[i]);

      // Asynchronous reset mid-word, asserted between clock edges.
      pv = '{1, W1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 1};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0};
      step(pv);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_out_data", out_data, 0);
      check("async_out_idx", out_idx, 0);
      check("async_out_last", out_last, 0);
      check("async_ld_ready", ld_ready, 0);
      check("async_msb_out_data", m_data, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_reset_ld_ready", ld_ready, 1);
      pv = '{1, W1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 1};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h1111, 16'h4444, 0, 0, 0};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h2222, 16'h3333, 1, 0, 0};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h3333, 16'h2222, 2, 0, 0};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h4444, 16'h1111, 3, 1, 1};
      step(pv);

`ifdef REG64_UNPACK_PARITY_EN
      pv = '{1, 64'h0000_0000_0003_0001, 1, 0, 0, 16'h0, 16'h0, 0, 0, 1};
      step(pv);
      pv = '{0, 0, 1, 0, 1, 16'h0001, 16'h0000, 0, 0, 0};
      step(pv);
      check("par_0001", out_par, 1);
      pv = '{0, 0, 1, 0, 1, 16'h0003, 16'h0000, 1, 0, 0};
      step(pv);
      check("par_0003", out_par, 0);
      pv = '{0, 0, 1, 0, 1, 16'h0000, 16'h0003, 2, 0, 0};
      step(pv);
      check("msb_par_0003", m_par, 0);
      pv = '{0, 0, 1, 0, 1, 16'h0000, 16'h0001, 3, 1, 1};
      step(pv);
      check("msb_par_0001", m_par, 1);
`endif

      pv = '{0, 0, 1, 0, 0, 16'h0, 16'h0, 0, 0, 1};
      step(pv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
